fp_add_seq: RTL
===============

Name: fp_add_seq

Overview:
- Multi-cycle IEEE-754 adder/sequencer for the floating-point adder datapath.
- Accepts one operand pair over a valid/ready handshake and steps through fixed phases: unpack/exponent select, alignment, add/subtract, normalize, round.
- Returns the result over a valid/ready handshake.
- Iterative shifting (1 bit/cycle) trades latency for area; one operation in flight at a time.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width (internal significand MAN_W+1 plus 3 GRS bits plus 1 carry bit).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  EXP_W+MAN_W+1  operand A, IEEE format
- b  in  EXP_W+MAN_W+1  operand B, IEEE format
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer accepts result
- result  out  EXP_W+MAN_W+1  sum, registered, held stable while out_valid=1
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0. rst in any state (including mid-ALIGN/NORM) aborts the operation; the operand is discarded.
- IDLE: on in_valid&in_ready, latch a,b, go to UNPACK.
- UNPACK (1 cycle):
  - Subnormal inputs (exp=0) are flushed to signed zero.
  - Specials: any NaN, or +inf with -inf, gives result=0x7FC00000 (qNaN). Otherwise any inf gives that inf. Specials go directly to DONE.
  - Exponent select: sel = (exp_b>exp_a) or (exp_b==exp_a and frac_b>frac_a). Large operand = sel?b:a. Result exponent and sign come from the large operand.
  - diff = exp_large-exp_small. If diff==0, go to ADD; otherwise go to ALIGN.
- ALIGN: small significand shifts right 1 bit/cycle, diff decrements, and shifted-out bits OR into sticky. If diff>27 on entry, the small significand collapses to sticky=(small!=0) in one cycle. Exit to ADD when diff reaches 0.
- ADD (1 cycle): same signs, add; different signs, large-small (never negative). A zero sum gives result +0 (-0 only if both inputs negative) and goes to DONE. Otherwise go to NORM.
- NORM:
  - If the carry bit is set: one cycle, shift right 1 (sticky kept), exp+1.
  - Else, while MSB=0: shift left 1/cycle, exp-1. If exp would reach 0, flush the result to signed zero and go to DONE.
  - If already normalized on entry: skip to ROUND without consuming a NORM cycle.
- ROUND (1 cycle): round-to-nearest-even on G,R,S.
  - Round-up carry-out: shift right, exp+1.
  - exp >= 2^EXP_W-1: result = signed inf.
  - Then go to DONE.
- DONE: out_valid=1, result stable. When out_ready=1, go to IDLE on the next edge (in_ready rises that cycle). There is no fall-through acceptance in DONE.
- Latency from the accept edge: 1 (UNPACK) + min(diff,28-ish per ALIGN rule) + 1 (ADD) + NORM cycles + 1 (ROUND), then DONE.
- Simultaneous in_valid during busy: ignored; in_ready=0, and the inputs are not sampled.

Test Plan:
- 0x3F800000 + 0x3F800000: UNPACK, ADD, NORM(carry, 1 cycle), ROUND, DONE. result=0x40000000 and out_valid asserted exactly 4 cycles after the accept edge.
- 0x3F800000 + 0x33800000 (diff 24, exact tie, even LSB): 24 ALIGN cycles, result=0x3F800000. 0x3F800001 + 0x33800000 (tie, odd LSB): result=0x3F800002.
- Cancellation 0x3F800001 + 0xBF800000: 23 NORM left shifts, result=0x34000000. 0x3F800000 + 0xBF800000: result=0x00000000, NORM and ROUND skipped.
- Overflow 0x7F7FFFFF + 0x7F7FFFFF: result=0x7F800000.
- Specials:
  - 0x7F800000 + 0xFF800000 gives 0x7FC00000.
  - 0x7F800000 + 0x3F800000 gives 0x7F800000.
  - A subnormal 0x00000001 + 0x3F800000 gives 0x3F800000.
  - Each special or subnormal case reaches DONE directly from UNPACK.
- Handshake/reset:
  - Hold out_ready=0 for 10 cycles in DONE: result and out_valid stay stable, in_ready=0, and new in_valid pulses are ignored.
  - Assert rst during the 10th ALIGN cycle of the diff-24 case: next cycle IDLE, in_ready=1, out_valid=0, busy=0. A fresh 1.0+1.0 then completes correctly.

Source files
------------

// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle IEEE-754 adder with 1-bit/cycle alignment and normalization.
// Subnormals are flushed to zero on input and output; rounding is round-to-nearest-even.
module fp_add_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 busy
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int SW = MAN_W + 5;
    localparam logic [EXP_W-1:0] EMAX  = '1;
    localparam logic [EXP_W-1:0] SHMAX = EXP_W'(SW - 1);
    localparam logic [EXP_W-1:0] D_ONE = EXP_W'(1);
    localparam logic [EXP_W:0]   E_ONE = (EXP_W + 1)'(1);
    localparam logic [W-1:0]     QNAN  = {1'b0, EMAX, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state;

    logic [W-1:0]     ra, rb;
    logic             sign, sub;
    logic [EXP_W:0]   exp;
    logic [EXP_W-1:0] diff;
    logic [SW-1:0]    sig_l, sig_s;

    logic             sa, sb, sel, nan_a, nan_b, inf_a, inf_b;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic [SW-1:0]    sum;
    logic [MAN_W+1:0] rnd;
    logic [EXP_W:0]   exp_r;
    logic [MAN_W-1:0] frac_r;

    assign {sa, ea, fa} = ra;
    assign {sb, eb, fb} = rb;
    assign nan_a = ea == EMAX && fa != '0;
    assign nan_b = eb == EMAX && fb != '0;
    assign inf_a = ea == EMAX && fa == '0;
    assign inf_b = eb == EMAX && fb == '0;
    assign sel   = eb > ea || (eb == ea && fb > fa);

    // significand layout: carry | hidden | fraction | guard | round | sticky
    assign sum    = sub ? sig_l - sig_s : sig_l + sig_s;
    assign rnd    = {1'b0, sig_l[SW-2:3]} + (MAN_W + 2)'(sig_l[2] & (sig_l[1] | sig_l[0] | sig_l[3]));
    assign exp_r  = exp + (EXP_W + 1)'(rnd[MAN_W+1]);
    assign frac_r = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra    <= a;
                    rb    <= b;
                    state <= UNPACK;
                end
                UNPACK: begin
                    state <= DONE;
                    if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) result <= QNAN;
                    else if (inf_a) result <= ra;
                    else if (inf_b) result <= rb;
                    else if (ea == '0 && eb == '0) result <= {sa & sb, {(W - 1){1'b0}}};
                    else if (ea == '0) result <= rb;
                    else if (eb == '0) result <= ra;
                    else begin
                        sign  <= sel ? sb : sa;
                        sub   <= sa ^ sb;
                        exp   <= {1'b0, sel ? eb : ea};
                        diff  <= sel ? eb - ea : ea - eb;
                        sig_l <= {2'b01, sel ? fb : fa, 3'b000};
                        sig_s <= {2'b01, sel ? fa : fb, 3'b000};
                        state <= ea == eb ? ADD : ALIGN;
                    end
                end
                ALIGN: if (diff > SHMAX) begin
                    sig_s <= {{(SW - 1){1'b0}}, |sig_s};
                    state <= ADD;
                end else begin
                    sig_s <= {1'b0, sig_s[SW-1:2], |sig_s[1:0]};
                    diff  <= diff - D_ONE;
                    if (diff == D_ONE) state <= ADD;
                end
                ADD: if (sum == '0) begin
                    result <= {sign & ~sub, {(W - 1){1'b0}}};
                    state  <= DONE;
                end else begin
                    sig_l <= sum;
                    state <= (sum[SW-1] || !sum[SW-2]) ? NORM : ROUND;
                end
                NORM: if (sig_l[SW-1]) begin
                    sig_l <= {1'b0, sig_l[SW-1:2], |sig_l[1:0]};
                    exp   <= exp + E_ONE;
                    state <= ROUND;
                end else if (exp == E_ONE) begin
                    result <= {sign, {(W - 1){1'b0}}};
                    state  <= DONE;
                end else begin
                    sig_l <= sig_l << 1;
                    exp   <= exp - E_ONE;
                    if (sig_l[SW-3]) state <= ROUND;
                end
                ROUND: begin
                    result <= exp_r >= {1'b0, EMAX} ? {sign, EMAX, {MAN_W{1'b0}}} : {sign, exp_r[EXP_W-1:0], frac_r};
                    state  <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
